// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage data RAM for the pipelined MIPS core.
// Word-organised synchronous RAM with byte/halfword lanes, load sign/zero
// extension and a stall output while a request is in flight.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses (no write, zero load data, addr_err pulse) instead of silently
// aligning them.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid,
    output logic        addr_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;
    logic                  r_err;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_start;
    logic                  w_enter_resp;
    logic                  w_blk;
    logic [3:0]            w_be;
    logic [31:0]           w_wlane;
    logic [31:0]           w_word;
    logic [31:0]           w_load;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_unused;

    // Address bits above the RAM window are don't-care.
    assign w_unused = ^req_addr[31:ADDR_WIDTH+2];

    assign w_idx   = r_addr[ADDR_WIDTH+1:2];
    assign w_start = (r_state == S_IDLE) && req_valid;
    // Reset wins over the access edge, so a pending store is dropped.
    assign w_enter_resp = !rst && ((w_start && (WAIT_CYCLES == 0)) ||
                                   ((r_state == S_WAIT) && (r_cnt == 4'd0)));
    assign stall_o = req_valid && (r_state != S_RESP);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_blk = ((r_size == 2'b01) && r_addr[0]) ||
                   (r_size[1] && (r_addr[1:0] != 2'b00));
`else
    assign w_blk = 1'b0;
`endif

    // Lane enables / replicated store data and load lane select + extension.
    // Halfword uses only addr[1] and word ignores addr[1:0], which aligns
    // misaligned requests when the check is disabled.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        w_word  = r_mem[w_idx];
        w_byte  = w_word[8*r_addr[1:0] +: 8];
        w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load  = w_word;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
                w_load  = {{24{r_signed & w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
                w_load  = {{16{r_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

    // Request FSM: capture in IDLE, count down in WAIT, one RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr   <= req_addr[ADDR_WIDTH+1:0];
                    r_size   <= req_size;
                    r_signed <= req_signed;
                    r_we     <= req_we;
                    r_wdata  <= req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM write of enabled lanes on the edge entering RESP; contents never reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && r_we && !w_blk) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
            end
        end
    end

    // Response registers: load data holds until the next load; pulses last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_enter_resp;
            r_err    <= w_enter_resp && w_blk;
            if (w_enter_resp) begin
                if (w_blk)      r_rdata <= 32'd0;
                else if (!r_we) r_rdata <= w_load;
            end
        end
    end

    assign rdata_o     = r_rdata;
    assign rdata_valid = r_rvalid;
    assign addr_err    = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (WAIT_CYCLES = 1).
// Expectations for the misaligned case follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_o(stall_o), .rdata_o(rdata_o),
        .rdata_valid(rdata_valid), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request starting just after a rising edge in IDLE; returns the
    // response seen in the rdata_valid cycle and the number of stalled cycles.
    task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output int nstall, output bit tmo);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        nstall = 0; tmo = 1'b1; rd = 32'd0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall_o) nstall++;
            if (rdata_valid) begin
                rd = rdata_o; err = addr_err; tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata_o !== 32'd0 || rdata_valid !== 1'b0 || stall_o !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdata_o=%h rvalid=%b stall=%b err=%b required 0/0/0/0",
                     rdata_o, rdata_valid, stall_o, addr_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic err; int ns; bit tmo;
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, ns, tmo);
        checks++;
        if (tmo || ns !== 2) begin
            errors++; $display("FAIL sw_stall: timeout=%0d stalls=%0d required 2", tmo, ns);
        end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || ns !== 2 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_word: timeout=%0d stalls=%0d data=%h required 2 deadbeef", tmo, ns, rd);
        end
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0 || rdata_o !== 32'hDEADBEEF || stall_o !== 1'b0) begin
            errors++; $display("FAIL pulse_hold: rvalid=%b data=%h stall=%b required 0 deadbeef 0",
                               rdata_valid, rdata_o, stall_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; logic err; int ns; bit tmo;
        logic [31:0] addrs [5] = '{32'h23, 32'h23, 32'h22, 32'h20, 32'h21};
        logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sgns  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, rd, err, ns, tmo);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, rd, err, ns, tmo);
            checks++;
            if (tmo || rd !== exps[i]) begin
                errors++; $display("FAIL lane_%0d: timeout=%0d data=%h required %h", i, tmo, rd, exps[i]);
            end
        end
    endtask

    task automatic test_partial;
        logic [31:0] rd; logic err; int ns; bit tmo;
        access(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd, err, ns, tmo);
        access(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAB, rd, err, ns, tmo);
        // Stores leave the last load value (lb @0x21 above) untouched.
        checks++;
        if (rdata_o !== 32'h0000007F) begin
            errors++; $display("FAIL store_hold: rdata_o=%h required 0000007f", rdata_o);
        end
        access(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234CDEF, rd, err, ns, tmo);
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || rd !== 32'hCDEFAB44) begin
            errors++; $display("FAIL partial: timeout=%0d data=%h required cdefab44", tmo, rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic err; int ns; bit tmo;
        access(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, err, ns, tmo);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h55;
        @(posedge clk); #1;          // now in WAIT
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'd0) begin
            errors++; $display("FAIL rst_mid_out: rvalid=%b stall=%b data=%h required 0 0 0",
                               rdata_valid, stall_o, rdata_o);
        end
        @(posedge clk); #1;
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || rd !== 32'h12345678) begin
            errors++; $display("FAIL rst_mid_drop: timeout=%0d data=%h required 12345678", tmo, rd);
        end
    endtask

    task automatic test_flush;
        logic [31:0] rd; logic err; int ns; bit tmo;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h50; req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;          // now in WAIT
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL flush_stall: stall=%b required 0", stall_o);
        end
        @(posedge clk); #1;          // RESP
        @(posedge clk); #1;          // IDLE
        access(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL flush_write: timeout=%0d data=%h required a5a5a5a5", tmo, rd);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic err; int ns; bit tmo;
        logic [31:0] exp_w, exp_h; logic exp_e;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_e = 1'b1; exp_w = 32'd0; exp_h = 32'd0;
`else
        exp_e = 1'b0; exp_w = 32'h12345678; exp_h = 32'h00001234;
`endif
        access(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || ns !== 2 || rd !== exp_w || err !== exp_e) begin
            errors++; $display("FAIL mis_word: timeout=%0d stalls=%0d data=%h err=%b required 2 %h %b",
                               tmo, ns, rd, err, exp_w, exp_e);
        end
        access(1'b0, 2'b01, 1'b1, 32'h43, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || rd !== exp_h || err !== exp_e) begin
            errors++; $display("FAIL mis_half: timeout=%0d data=%h err=%b required %h %b",
                               tmo, rd, err, exp_h, exp_e);
        end
        // Aligned access afterwards must not flag an error.
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, err, ns, tmo);
        checks++;
        if (tmo || rd !== 32'h12345678 || err !== 1'b0) begin
            errors++; $display("FAIL aligned_after: timeout=%0d data=%h err=%b required 12345678 0", tmo, rd, err);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic err; int ns; bit tmo;
        int t0, t1;
        t0 = $time;
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, ns, tmo);
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, err, ns, tmo);
        t1 = $time;
        checks++;
        if (tmo || rd !== 32'hCDEFAB44 || (t1 - t0) !== 60) begin
            errors++; $display("FAIL back_to_back: timeout=%0d data=%h elapsed=%0d required cdefab44 60",
                               tmo, rd, t1 - t0);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_partial();
        test_reset_mid();
        test_flush();
        test_misaligned();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. It sits on the memory-stage side of the core and serves the load/store requests the datapath issues (ALU result as address, forwarded rt value as store data). It holds a word-organised synchronous RAM and applies byte/halfword lane selection and load sign/zero extension. A stall output freezes the pipeline while an access is in flight.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra access cycles inserted before the response; legal range 0..15.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  memory-stage instruction is a load or store.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_signed  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- req_addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word, upper bits are ignored.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- stall_o  output  1  combinational; holds the pipeline while the request is not yet answered.
- rdata_o  output  32  extended load data; registered.
- rdata_valid  output  1  high for exactly the response cycle.
- addr_err  output  1  misaligned request, high in the response cycle (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req_valid=1: capture address, size, signed, we and wdata. Go to WAIT if WAIT_CYCLES>0 (count = WAIT_CYCLES-1), else go to RESP.
  - WAIT: if count = 0, go to RESP; otherwise decrement.
  - RESP: go to IDLE unconditionally.
- RAM access happens on the edge that enters RESP, using only the captured request fields:
  - Store: write only the enabled lanes.
  - Load: read the word, select the lane, extend, and register into rdata_o.
- Lanes are little-endian. Byte lane k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane = addr[1] (0 → [15:0], 1 → [31:16]).
- A store never changes rdata_o. A load returns the pre-write contents of any same-cycle write (there is none, since only one request is in flight).
- stall_o = req_valid & (state != RESP). In RESP, stall_o=0, so the pipeline advances on that edge and the next request is sampled in IDLE on the following cycle.
- RAM contents are not cleared by reset; a load before any store returns X in simulation.

## Timing
- Reset values: state IDLE, count 0, rdata_o 0, rdata_valid 0, addr_err 0, captured fields 0. stall_o follows req_valid in IDLE.
- Request latency is WAIT_CYCLES+1 stalled cycles, plus 1 response cycle. With WAIT_CYCLES=0, one stall cycle, then the response.
- Back-to-back requests: RESP → IDLE costs one cycle, so each access occupies WAIT_CYCLES+2 cycles. In the IDLE cycle between requests, stall_o is asserted if req_valid is high.
- rdata_o holds its last load value until the next load response. rdata_valid and addr_err are single-cycle pulses.
- Reset during WAIT: return to IDLE and drop the pending store (no RAM write). Reset on the RESP edge: the write already performed stays.
- req_valid dropping mid-access (caused by a flush): the access still completes and the RAM write still occurs. The pipeline ignores the response.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, still follows the full FSM timing.
  - The RAM is not written, rdata_o is loaded with 0, and addr_err=1 in RESP.
- DMEM_ALIGN_CHECK_EN undefined:
  - Misaligned low bits are ignored: word forces [1:0]=0, halfword forces [0]=0.
  - The access proceeds normally and addr_err is tied 0.

## Test plan
- Reset then idle: rst=1 for 2 cycles, req_valid=0 → rdata_o=0, rdata_valid=0, stall_o=0, addr_err=0.
- Word store/load with WAIT_CYCLES=1: sw 0xDEADBEEF @0x10, then lw @0x10 → stall_o high for 2 cycles per access; rdata_o=0xDEADBEEF with rdata_valid in the 3rd cycle.
- Byte lanes: after word 0x80FF7F01 @0x20:
  - lb @0x23 → 0xFFFFFF80
  - lbu @0x23 → 0x00000080
  - lh @0x22 → 0xFFFF80FF
  - lhu @0x20 → 0x00007F01
- Partial store: word 0x11223344 @0x30, sb 0xAB @0x31, sh 0xCDEF @0x32, lw @0x30 → 0xCDEFAB44.
- Reset mid-access: sw 0x55 @0x40 into WAIT with WAIT_CYCLES=3, pulse rst in the 2nd WAIT cycle, then lw @0x40 → the previous value (0x0 if pre-initialised) is returned; the store was dropped.
- Misaligned: lw @0x42 with DMEM_ALIGN_CHECK_EN → addr_err=1, rdata_o=0. Without the macro → addr_err=0 and the data at word 0x40 is returned.
